magic_nor_sequencer: RTL and testbench

Sequencer that evaluates a NOR-only netlist (ABC NOR-mapped benchmarks such as the 7-input rd73 family) as a MAGIC in-memory computation. It holds a program of NOR micro-ops and a bit-cell array that models one crossbar row. For each op it issues the MAGIC two-step sequence: INIT the output cell to 1, then EVAL output = NOR(a, b). It sits between the host and the crossbar model, replacing the combinational netlist with a time-multiplexed single NOR resource.

---
 rtl/magic_nor_sequencer.sv | 148 ++++++++++++++
 tb/tb_magic_nor_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/magic_nor_sequencer.sv
// MAGIC in-memory NOR sequencer: runs a stored program of NOR micro-ops on a
// one-row bit-cell array, two cycles (INIT then EVAL) per op.
module magic_nor_sequencer #(
  parameter int ADDR_W = 7,
  parameter int PC_W   = 7,
  parameter int NIN    = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [PC_W-1:0]       prog_addr,
  input  logic [3*ADDR_W-1:0]   prog_data,
  input  logic                  start,
  input  logic [PC_W:0]         op_count,
  input  logic [ADDR_W-1:0]     out_addr,
  input  logic [NIN-1:0]        x,
  output logic                  busy,
  output logic                  done,
  output logic                  result,
  output logic                  illegal_op
);

  localparam int NCELL  = 2 ** ADDR_W;
  localparam int PDEPTH = 2 ** PC_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_INIT = 3'd2,
    S_EVAL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  logic [PC_W-1:0]       r_pc;
  logic [PC_W:0]         r_cnt;
  logic [ADDR_W-1:0]     r_out_addr;
  logic [NIN-1:0]        r_x;
  logic [NCELL-1:0]      r_cells;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_result;
  logic                  r_illegal;
  logic [3*ADDR_W-1:0]   r_mem [PDEPTH];

  logic [3*ADDR_W-1:0]   w_op;
  logic [ADDR_W-1:0]     w_dst;
  logic [ADDR_W-1:0]     w_srca;
  logic [ADDR_W-1:0]     w_srcb;
  logic [PC_W:0]         w_pc_inc;
  logic                  w_illegal;

  // The op stays addressed by r_pc across INIT and EVAL, and the program
  // memory is frozen outside IDLE, so both phases decode the same word.
  assign w_op      = r_mem[r_pc];
  assign w_dst     = w_op[3*ADDR_W-1:2*ADDR_W];
  assign w_srca    = w_op[2*ADDR_W-1:ADDR_W];
  assign w_srcb    = w_op[ADDR_W-1:0];
  assign w_pc_inc  = {1'b0, r_pc} + {{PC_W{1'b0}}, 1'b1};
  assign w_illegal = (w_dst == w_srca) || (w_dst == w_srcb);

  // Program memory write port, open only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_IDLE) && prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // Sequencer FSM, cell array and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= {PC_W{1'b0}};
      r_cnt      <= {(PC_W+1){1'b0}};
      r_out_addr <= {ADDR_W{1'b0}};
      r_x        <= {NIN{1'b0}};
      r_cells    <= {NCELL{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt      <= op_count;
            r_out_addr <= out_addr;
            r_x        <= x;
            r_illegal  <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < NIN; i++) begin
            r_cells[i] <= r_x[i];
          end
          r_pc <= {PC_W{1'b0}};
          if (r_cnt != {(PC_W+1){1'b0}}) begin
            r_state <= S_INIT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_INIT: begin
          r_cells[w_dst] <= 1'b1;
          if (w_illegal) begin
            r_illegal <= 1'b1;
          end else begin
            r_illegal <= r_illegal;
          end
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          // Sources read the post-INIT array, so an op that reads its own
          // destination sees 1 and evaluates to 0.
          r_cells[w_dst] <= ~(r_cells[w_srca] | r_cells[w_srcb]);
          r_pc           <= w_pc_inc[PC_W-1:0];
          if (w_pc_inc < r_cnt) begin
            r_state <= S_INIT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_result <= r_cells[r_out_addr];
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Directed, table-driven bench for magic_nor_sequencer with hand-computed
// expectations plus hand-written multi-cycle sequences.
module tb_magic_nor_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [6:0]  prog_addr = 7'd0;
  logic [20:0] prog_data = 21'd0;
  logic        start = 1'b0;
  logic [7:0]  op_count = 8'd0;
  logic [6:0]  out_addr = 7'd0;
  logic [6:0]  x = 7'd0;
  logic        busy, done, result, illegal_op;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [6:0] d0, a0, b0, d1, a1, b1;
    logic [7:0] n;
    logic [6:0] oa;
    logic [6:0] xv;
    logic       er;
    logic       ei;
  } vec_t;

  vec_t vecs[12];

  magic_nor_sequencer #(.ADDR_W(7), .PC_W(7), .NIN(7)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .op_count(op_count),
    .out_addr(out_addr), .x(x), .busy(busy), .done(done),
    .result(result), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_op(input logic [6:0] a, input logic [6:0] d,
                          input logic [6:0] sa, input logic [6:0] sb);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = {d, sa, sb};
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] n, input logic [6:0] oa,
                           input logic [6:0] xv);
    @(negedge clk);
    op_count = n; out_addr = oa; x = xv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called #1 after the start edge; counts edges until done and busy samples.
  task automatic wait_done(output int cyc, output int bcyc);
    cyc = 0;
    bcyc = busy ? 1 : 0;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) bcyc++;
    end
  endtask

  task automatic run_check(input string name, input logic [7:0] n,
                           input logic [6:0] oa, input logic [6:0] xv,
                           input logic er, input logic ei);
    int cyc, bcyc;
    start_run(n, oa, xv);
    wait_done(cyc, bcyc);
    check({name, " latency"}, cyc, 2 + 2 * int'(n));
    check({name, " busy_cycles"}, bcyc, 2 * int'(n) + 1);
    check({name, " result"}, int'(result), int'(er));
    check({name, " illegal_op"}, int'(illegal_op), int'(ei));
    @(posedge clk); #1;
    check({name, " done_pulse_width"}, int'(done), 0);
  endtask

  initial begin
    int cyc, bcyc, extra;

    vecs[0]  = '{7'd7, 7'd0, 7'd1, 7'd8, 7'd7, 7'd7, 8'd2, 7'd8, 7'b0000010, 1'b1, 1'b0};
    vecs[1]  = '{7'd7, 7'd0, 7'd1, 7'd8, 7'd7, 7'd7, 8'd2, 7'd8, 7'b0000000, 1'b0, 1'b0};
    vecs[2]  = '{7'd7, 7'd0, 7'd1, 7'd8, 7'd7, 7'd7, 8'd0, 7'd3, 7'b0001000, 1'b1, 1'b0};
    vecs[3]  = '{7'd7, 7'd0, 7'd1, 7'd8, 7'd7, 7'd7, 8'd0, 7'd7, 7'b0000000, 1'b1, 1'b0};
    vecs[4]  = '{7'd7, 7'd0, 7'd1, 7'd8, 7'd7, 7'd7, 8'd0, 7'd8, 7'b0000000, 1'b0, 1'b0};
    vecs[5]  = '{7'd7, 7'd0, 7'd1, 7'd8, 7'd7, 7'd7, 8'd2, 7'd8, 7'b0000001, 1'b1, 1'b0};
    vecs[6]  = '{7'd10, 7'd3, 7'd3, 7'd0, 7'd0, 7'd0, 8'd1, 7'd10, 7'b0001000, 1'b0, 1'b0};
    vecs[7]  = '{7'd10, 7'd3, 7'd3, 7'd0, 7'd0, 7'd0, 8'd1, 7'd10, 7'b0000000, 1'b1, 1'b0};
    vecs[8]  = '{7'd9, 7'd9, 7'd2, 7'd0, 7'd0, 7'd0, 8'd1, 7'd9, 7'b0000000, 1'b0, 1'b1};
    vecs[9]  = '{7'd11, 7'd4, 7'd11, 7'd0, 7'd0, 7'd0, 8'd1, 7'd11, 7'b1111111, 1'b0, 1'b1};
    vecs[10] = '{7'd12, 7'd5, 7'd6, 7'd0, 7'd0, 7'd0, 8'd1, 7'd12, 7'b0000000, 1'b1, 1'b0};
    vecs[11] = '{7'd12, 7'd5, 7'd6, 7'd0, 7'd0, 7'd0, 8'd0, 7'd12, 7'b0000000, 1'b1, 1'b0};

    #2;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset result", int'(result), 0);
    check("reset illegal_op", int'(illegal_op), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      write_op(7'd0, vecs[i].d0, vecs[i].a0, vecs[i].b0);
      write_op(7'd1, vecs[i].d1, vecs[i].a1, vecs[i].b1);
      run_check($sformatf("vec%0d", i), vecs[i].n, vecs[i].oa, vecs[i].xv,
                vecs[i].er, vecs[i].ei);
    end

    // Write in the same cycle as start must be used by that run.
    write_op(7'd0, 7'd7, 7'd0, 7'd1);
    @(negedge clk);
    op_count = 8'd1; out_addr = 7'd7; x = 7'b0001000; start = 1'b1;
    prog_we = 1'b1; prog_addr = 7'd0; prog_data = {7'd7, 7'd3, 7'd3};
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    wait_done(cyc, bcyc);
    check("we_with_start result", int'(result), 0);

    // Start and prog_we mid-run are ignored.
    write_op(7'd0, 7'd7, 7'd0, 7'd1);
    write_op(7'd1, 7'd8, 7'd7, 7'd7);
    start_run(8'd2, 7'd8, 7'b0000010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b1; prog_we = 1'b1; prog_addr = 7'd0; prog_data = {7'd7, 7'd0, 7'd0};
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    wait_done(cyc, bcyc);
    check("busy_prot result", int'(result), 1);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("busy_prot extra_done", extra, 0);
    run_check("busy_prot readback", 8'd2, 7'd8, 7'b0000010, 1'b1, 1'b0);

    // Async reset during EVAL of the second op.
    write_op(7'd0, 7'd9, 7'd9, 7'd2);
    start_run(8'd2, 7'd8, 7'b0000000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("pre_reset busy", int'(busy), 1);
    check("pre_reset illegal_op", int'(illegal_op), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst busy", int'(busy), 0);
    check("async_rst done", int'(done), 0);
    check("async_rst result", int'(result), 0);
    check("async_rst illegal_op", int'(illegal_op), 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check("post_reset quiet", extra, 0);
    write_op(7'd0, 7'd7, 7'd0, 7'd1);
    run_check("post_reset rerun", 8'd2, 7'd8, 7'b0000010, 1'b1, 1'b0);

    // Full-length alternating NOT chain: 128 ops ending in cell 8.
    write_op(7'd0, 7'd7, 7'd0, 7'd0);
    for (int i = 1; i < 128; i++) begin
      if (i % 2 == 1) write_op(7'(i), 7'd8, 7'd7, 7'd7);
      else            write_op(7'(i), 7'd7, 7'd8, 7'd8);
    end
    run_check("full x0=1", 8'd128, 7'd8, 7'b0000001, 1'b1, 1'b0);
    run_check("full x0=0", 8'd128, 7'd8, 7'b1111110, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
